// File: rtl/coeff_token_encoder.sv
//============================================================================
// coeff_token_encoder: serialises the H.264 CAVLC coeff_token codeword, MSB first.
// Optional nC==-1 chroma DC column: define COEFF_TOKEN_CHROMA_DC_EN.  Rev 1.0
//============================================================================
`default_nettype none
module coeff_token_encoder #(
  parameter int ERR_STICKY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] total_coeff,
  input  logic [1:0] trailing_ones,
  input  logic [2:0] nc_sel,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // One nibble per TotalCoeff*4+TrailingOnes: codeword value (VAL*) and length-1 (LEN*).
  localparam logic [0:67][3:0] VAL0 =
    272'h1000_5100_7410_7653_7653_7654_F654_BE54_8AD4_FE94_BADC_FE9C_BAD8_F19C_BED8_7A9C_4658;
  localparam logic [0:67][3:0] LEN0 =
    272'h0000_5100_7520_8764_9875_A986_CA97_CCA8_CCC9_DDCA_DDDC_EEDD_EEED_FEEE_FFFE_FFFF_FFFF;
  localparam logic [0:67][3:0] VAL1 =
    272'h3000_B200_7730_7A95_7654_4656_7658_F654_BED4_FA94_BEDC_8A98_FEDC_BA9C_7B68_98A1_7654;
  localparam logic [0:67][3:0] LEN1 =
    272'h1000_5100_5420_6553_7553_7664_8775_A885_AAA6_BAA8_BBBA_BBBA_CCCB_CCCC_CDCC_DDDC_DDDD;
  localparam logic [0:67][3:0] VAL2 =
    272'hF000_FE00_BFD0_8CEC_FABB_B89A_9ED9_8A98_FEDD_BEAC_FADC_BE9C_8AD8_D79C_9CBA_5876_1432;
  localparam logic [0:67][3:0] LEN2 =
    272'h3000_5300_5430_5443_6443_6443_6553_6553_7664_7765_8776_8877_8887_9888_9999_9999_9999;
`ifdef COEFF_TOKEN_CHROMA_DC_EN
  localparam logic [0:19][3:0] VALC = 80'h1000_7100_4610_3325_2320;
  localparam logic [0:19][3:0] LENC = 80'h1000_5000_5520_5665_5776;
`endif

  logic [0:0]  state, state_nxt;
  logic [15:0] shreg;
  logic [4:0]  count;
  logic        illegal, accept, advance;
  logic [6:0]  tidx;
  logic [15:0] code, code_al;
  logic [4:0]  len;

  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready;

  always_comb begin
    illegal = ({3'b000, trailing_ones} > total_coeff) || (total_coeff > 5'd16) || (nc_sel > 3'd4);
`ifdef COEFF_TOKEN_CHROMA_DC_EN
    if (nc_sel == 3'd4 && total_coeff > 5'd4) illegal = 1'b1;
`else
    if (nc_sel == 3'd4) illegal = 1'b1;
`endif
  end

  always_comb begin
    tidx = (total_coeff > 5'd16) ? 7'd0 : {total_coeff, trailing_ones};
    code = 16'd0;
    len  = 5'd1;
    case (nc_sel)
      3'd0: begin code = {12'd0, VAL0[tidx]}; len = {1'b0, LEN0[tidx]} + 5'd1; end
      3'd1: begin code = {12'd0, VAL1[tidx]}; len = {1'b0, LEN1[tidx]} + 5'd1; end
      3'd2: begin code = {12'd0, VAL2[tidx]}; len = {1'b0, LEN2[tidx]} + 5'd1; end
      3'd3: begin
        // Fixed-length: TotalCoeff-1 (16 wraps to 4'hF) then TrailingOnes; zero is 000011.
        len  = 5'd6;
        code = (total_coeff == 5'd0) ? 16'd3
                                     : {10'd0, total_coeff[3:0] - 4'd1, trailing_ones};
      end
`ifdef COEFF_TOKEN_CHROMA_DC_EN
      3'd4: begin
        code = {12'd0, VALC[(total_coeff > 5'd4) ? 5'd0 : tidx[4:0]]};
        len  = {1'b0, LENC[(total_coeff > 5'd4) ? 5'd0 : tidx[4:0]]} + 5'd1;
      end
`endif
      default: ;
    endcase
    code_al = code << (5'd16 - len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && !illegal) state_nxt = ST_SHIFT;
      ST_SHIFT: if (advance && count == 5'd1) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_SHIFT);
    out_last  = (state == ST_SHIFT) && (count == 5'd1);
    out_bit   = shreg[15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= 16'd0;
      count <= 5'd0;
    end else if (accept && !illegal) begin
      shreg <= code_al;
      count <= len;
    end else if (advance) begin
      shreg <= {shreg[14:0], 1'b0};
      count <= count - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err <= 1'b0;
    else if (ERR_STICKY != 0) err <= err | (accept && illegal);
    else                      err <= accept && illegal;
  end
endmodule
`default_nettype wire

// File: doc/coeff_token_encoder.md
COEFF_TOKEN_ENCODER -- requirements
Module: coeff_token_encoder

Interface
REQ-001 Parameter ERR_STICKY, default 0: 0 = Err is a one-cycle pulse; 1 = Err stays high until reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 InValid  input  1  token request valid.
REQ-005 InReady  output  1  encoder can accept a token.
REQ-006 TotalCoeff  input  5  number of nonzero coefficients, 0..16.
REQ-007 TrailingOnes  input  2  trailing +/-1 count, 0..3.
REQ-008 NcSel  input  3  table select: 0 = 0<=nC<2; 1 = 2<=nC<4; 2 = 4<=nC<8; 3 = 8<=nC; 4 = nC==-1 (chroma DC).
REQ-009 OutBit  output  1  serial coeff_token bit, MSB of codeword first.
REQ-010 OutValid  output  1  OutBit valid.
REQ-011 OutReady  input  1  downstream accepts OutBit.
REQ-012 OutLast  output  1  high with the final bit of a codeword.
REQ-013 Err  output  1  illegal token request flag.

Function
REQ-014 The block SHALL encode coeff_token per H.264 Table 9-5 (column chosen by NcSel) into a codeword of 1..16 bits, held left-aligned in a 16-bit register with a 5-bit length.
REQ-015 The FSM SHALL have the states IDLE and SHIFT.
- IDLE: InReady=1, OutValid=0.
- SHIFT: InReady=0, OutValid=1.
REQ-016 The input handshake SHALL complete on the cycle where InValid and InReady are both high; TotalCoeff, TrailingOnes and NcSel are sampled only on that cycle.
REQ-017 A legal accepted token SHALL cause a transition to SHIFT on the next cycle, with OutBit = codeword MSB (latency 1 cycle from accept to first bit).
REQ-018 In SHIFT, each cycle with OutValid and OutReady both high SHALL advance one bit and decrement the remaining count.
REQ-019 While OutReady is low, OutBit and OutLast SHALL hold stable.
REQ-020 OutLast SHALL be high exactly when the remaining count is 1.
REQ-021 The OutLast handshake SHALL return the FSM to IDLE, with InReady high on the next cycle. Per-token occupancy is Len+1 cycles with OutReady held high.
REQ-022 A token is illegal if any of the following holds:
- TrailingOnes > TotalCoeff;
- TotalCoeff > 16;
- NcSel > 4;
- NcSel==4 with TotalCoeff > 4;
- NcSel==4 when CHROMA_DC is compiled out (REQ-029).
An illegal token SHALL be consumed by the handshake, SHALL emit no bits, SHALL keep the FSM in IDLE, and SHALL assert Err the next cycle.
REQ-023 For NcSel==3 the code SHALL be a 6-bit FLC: 4 bits of TotalCoeff-1 followed by 2 bits of TrailingOnes. TotalCoeff==0 SHALL encode as 000011.
REQ-024 InReady SHALL depend only on state; there is no combinational path from OutReady to InReady.

Reset
REQ-025 Rst high SHALL immediately force state IDLE, InReady=1, OutValid=0, OutLast=0, OutBit=0, Err=0, and clear the shift register and count.
REQ-026 Rst asserted during SHIFT SHALL abort the codeword; no remaining bits are emitted after Rst deasserts.
REQ-027 The first handshake SHALL be possible on the first rising edge after Rst deasserts.

Configuration
REQ-028 Macro COEFF_TOKEN_CHROMA_DC_EN defined: the nC==-1 column (NcSel==4) SHALL be compiled in. Example: TotalCoeff=0, TrailingOnes=0 encodes as 01.
REQ-029 Macro COEFF_TOKEN_CHROMA_DC_EN undefined: the chroma DC table SHALL be absent, and NcSel==4 SHALL be handled as illegal per REQ-022.

Verification
REQ-030 NcSel=0, TotalCoeff=0, TrailingOnes=0, OutReady=1 -> one bit 1 with OutLast high, on the cycle after accept; InReady high again 2 cycles after accept.
REQ-031 NcSel=0, TotalCoeff=6, TrailingOnes=0 -> 13 bits 0000000001111, OutLast only on the 13th bit; NcSel=0, TotalCoeff=10, TrailingOnes=3 -> 0000000001100.
REQ-032 NcSel=3, TotalCoeff=5, TrailingOnes=2 -> 010010. Toggle OutReady low for 3 cycles mid-word -> OutBit/OutLast stable and no bit lost or duplicated.
REQ-033 TotalCoeff=1, TrailingOnes=2 -> Err high for 1 cycle (ERR_STICKY=0) or held until reset (ERR_STICKY=1); OutValid stays 0.
REQ-034 Assert Rst on the 4th bit of a 13-bit word -> OutValid low immediately; after release, InReady=1 and a new token NcSel=1, TotalCoeff=0 -> bits 11.
REQ-035 NcSel=4, TotalCoeff=0, TrailingOnes=0 -> bits 01 with COEFF_TOKEN_CHROMA_DC_EN defined; Err pulse and no bits with the macro undefined.
